// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for tiny N
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO-write bundle for the arbiter
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 8
);
    localparam int IW = clog2_min1(N);

    logic [N-1:0]   req_i;
    logic [N*B-1:0] data_i;
    logic [N-1:0]   ack_o;
    logic           fifo_wr_o;
    logic [B-1:0]   fifo_wdata_o;
    logic           fifo_full_i;
    logic [IW-1:0]  owner_o;
    logic           busy_o;

    // Requester/FIFO side: drives requests, data and the full flag
    modport master (
        output req_i, data_i, fifo_full_i,
        input  ack_o, fifo_wr_o, fifo_wdata_o, owner_o, busy_o
    );

    // Arbiter side
    modport slave (
        input  req_i, data_i, fifo_full_i,
        output ack_o, fifo_wr_o, fifo_wdata_o, owner_o, busy_o
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Walk offsets from farthest to nearest so the nearest set bit after last wins
    always_comb begin
        int idx;
        idx   = 0;
        valid = 1'b0;
        index = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                valid = 1'b1;
                index = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int B         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_i,
    fifo_wr_arbiter_if.slave   bus
);

    localparam int IW = clog2_min1(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          wr_en;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (bus.req_i),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // State register; reset abandons any burst and restarts the search at requester 0
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: arbitrate in IDLE, count writes and decide burst end in GRANT
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (wr_en) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!bus.req_i[owner_q] || (wr_en && (cnt_q == CW'(MAX_BURST - 1)))) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a write happens only while granted, requested and the FIFO has room
    always_comb begin
        wr_en            = 1'b0;
        bus.ack_o        = '0;
        bus.fifo_wdata_o = '0;
        if (state_q == GRANT) begin
            wr_en            = bus.req_i[owner_q] & ~bus.fifo_full_i;
            bus.ack_o[owner_q] = wr_en;
            bus.fifo_wdata_o = bus.data_i[int'(owner_q) * B +: B];
        end
        bus.fifo_wr_o = wr_en;
        bus.busy_o    = (state_q == GRANT);
        bus.owner_o   = owner_q;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int B     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_i;

    fifo_wr_arbiter_if #(.N(N), .B(B)) bus();

    fifo_wr_arbiter #(.N(N), .B(B), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int ncyc    = 0;
    int nwrites = 0;

    logic [7:0] src_q [N][$];
    logic [7:0] fifo_q [$];
    int         w_owner [$];
    int         w_cyc [$];

    logic [N-1:0] req_on;
    logic         rd_now;
    logic [7:0]   rd_data;

    logic         s_wr, s_busy, s_full;
    logic [N-1:0] s_ack;
    logic [7:0]   s_wdata;
    logic [1:0]   s_owner;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.req_i[k] = req_on[k] && (src_q[k].size() > 0);
            bus.data_i[k*B +: B] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
        end
        bus.fifo_full_i = (fifo_q.size() >= DEPTH);
    endtask

    task automatic sample();
        s_wr    = bus.fifo_wr_o;
        s_ack   = bus.ack_o;
        s_wdata = bus.fifo_wdata_o;
        s_owner = bus.owner_o;
        s_busy  = bus.busy_o;
        s_full  = bus.fifo_full_i;
        chk("ack_onehot0", 32'($onehot0(s_ack)), 1);
        chk("wr_is_or_ack", s_wr, |s_ack);
        chk("no_wr_when_full", s_wr & s_full, 0);
        chk("ack_only_to_req", s_ack & ~bus.req_i, 0);
    endtask

    task automatic commit();
        if (rd_now && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
        for (int k = 0; k < N; k++) begin
            if (s_ack[k]) begin
                chk("ack_has_data", src_q[k].size() != 0, 1);
                if (src_q[k].size() != 0) begin
                    chk($sformatf("wdata_req%0d", k), s_wdata, src_q[k][0]);
                    void'(src_q[k].pop_front());
                end
                fifo_q.push_back(s_wdata);
                nwrites++;
                w_owner.push_back(k);
                w_cyc.push_back(ncyc);
            end
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        sample();
        @(posedge clk);
        #1;
        commit();
        ncyc++;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        req_on = '0;
        rd_now = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        fifo_q.delete();
        w_owner.delete();
        w_cyc.delete();
        drive();
        #1;
        sample();
        chk("rst_wr", s_wr, 0);
        chk("rst_ack", s_ack, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_owner", s_owner, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t      = 0;
        req_on = '0;
        rd_now = 1'b1;
        while (fifo_q.size() > 0 && t < 100) begin
            cycle();
            t++;
        end
        chk("drain_empty", fifo_q.size(), 0);
        rd_now = 1'b0;
    endtask

    initial begin
        logic [7:0] t1_exp [3];
        int t, pushed, base, remaining;

        t1_exp = '{8'hA5, 8'h5A, 8'h3C};
        rst_i  = 1'b1;
        req_on = '0;
        rd_now = 1'b0;
        bus.req_i = '0;
        bus.data_i = '0;
        bus.fifo_full_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: single requester, three words
        do_reset();
        src_q[2].push_back(8'hA5);
        src_q[2].push_back(8'h5A);
        src_q[2].push_back(8'h3C);
        req_on = 4'b0100;
        cycle();
        chk("t1_idle_busy", s_busy, 0);
        chk("t1_idle_wr", s_wr, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_busy", s_busy, 1);
            chk("t1_owner", s_owner, 2);
            chk("t1_ack", s_ack, 4'b0100);
        end
        cycle();
        chk("t1_drop_wr", s_wr, 0);
        chk("t1_drop_busy", s_busy, 1);
        cycle();
        chk("t1_idle_after", s_busy, 0);
        rd_now = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_readback", rd_data, t1_exp[i]);
        end
        rd_now = 1'b0;

        // 2: all four requesting, round-robin bursts fill the FIFO
        do_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 8; j++) src_q[k].push_back(8'(k * 16 + j));
        req_on = '1;
        t = 0;
        while (w_owner.size() < 16 && t < 80) begin
            cycle();
            t++;
        end
        chk("t2_write_count", w_owner.size(), 16);
        for (int i = 0; i < 16 && i < w_owner.size(); i++)
            chk("t2_owner_seq", w_owner[i], i / 4);
        for (int i = 0; i < 15 && i + 1 < w_cyc.size(); i++)
            chk("t2_gap", w_cyc[i+1] - w_cyc[i], (i % 4 == 3) ? 2 : 1);
        chk("t2_fifo_full", fifo_q.size(), 16);
        cycle();
        chk("t2_bubble_busy", s_busy, 0);
        cycle();
        chk("t2_stall_busy", s_busy, 1);
        chk("t2_stall_owner", s_owner, 0);
        chk("t2_stall_wr", s_wr, 0);
        drain();

        // 3: full stall, one read lets exactly one word through
        do_reset();
        for (int j = 0; j < DEPTH; j++) fifo_q.push_back(8'hEE);
        src_q[0].push_back(8'h70);
        src_q[0].push_back(8'h71);
        req_on = 4'b0001;
        cycle();
        chk("t3_idle_busy", s_busy, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_stall_busy", s_busy, 1);
            chk("t3_stall_owner", s_owner, 0);
            chk("t3_stall_wr", s_wr, 0);
            chk("t3_stall_ack", s_ack, 0);
        end
        rd_now = 1'b1;
        cycle();
        rd_now = 1'b0;
        chk("t3_rd_cycle_wr", s_wr, 0);
        cycle();
        chk("t3_one_wr", s_wr, 1);
        chk("t3_one_ack", s_ack, 4'b0001);
        cycle();
        chk("t3_restall_wr", s_wr, 0);
        chk("t3_restall_busy", s_busy, 1);
        drain();

        // 4: early drop, next search starts after the dropped owner
        do_reset();
        src_q[1].push_back(8'h11);
        src_q[1].push_back(8'h12);
        req_on = 4'b0010;
        cycle();
        chk("t4_idle_busy", s_busy, 0);
        src_q[0].push_back(8'h01);
        src_q[3].push_back(8'h31);
        req_on = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("t4_owner1", s_owner, 1);
            chk("t4_ack1", s_ack, 4'b0010);
        end
        cycle();
        chk("t4_drop_wr", s_wr, 0);
        cycle();
        chk("t4_idle_busy2", s_busy, 0);
        cycle();
        chk("t4_next_owner", s_owner, 3);
        chk("t4_next_ack", s_ack, 4'b1000);
        drain();

        // 5: asynchronous reset mid-burst
        do_reset();
        for (int j = 0; j < 4; j++) src_q[1].push_back(8'(8'h21 + j));
        req_on = 4'b0010;
        cycle();
        cycle();
        cycle();
        chk("t5_writes_before_rst", w_owner.size(), 2);
        drive();
        #1;
        sample();
        chk("t5_pre_rst_wr", s_wr, 1);
        rst_i = 1'b1;
        #1;
        sample();
        chk("t5_rst_wr", s_wr, 0);
        chk("t5_rst_ack", s_ack, 0);
        chk("t5_rst_busy", s_busy, 0);
        chk("t5_rst_owner", s_owner, 0);
        @(posedge clk);
        #1;
        src_q[1].delete();
        src_q[0].push_back(8'h41);
        src_q[3].push_back(8'h43);
        req_on = 4'b1001;
        drive();
        #1;
        sample();
        chk("t5_held_busy", s_busy, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cycle();
        chk("t5_rel_idle", s_busy, 0);
        cycle();
        chk("t5_rel_owner", s_owner, 0);
        chk("t5_rel_ack", s_ack, 4'b0001);
        drain();

        // 6: random requests and reads; per-requester order checked on every ack
        do_reset();
        pushed = 0;
        base   = nwrites;
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() < 3) begin
                    src_q[k].push_back(8'($urandom));
                    pushed++;
                end
            end
            if ($urandom_range(0, 7) == 0) req_on = 4'($urandom);
            rd_now = 1'($urandom_range(0, 1));
            cycle();
        end
        remaining = 0;
        for (int k = 0; k < N; k++) remaining += src_q[k].size();
        chk("t6_progress", (nwrites - base) > 50, 1);
        chk("t6_accounting", nwrites - base, pushed - remaining);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
